ahb_lite_decoder_mux: RTL and testbench

- Parametrised AHB-lite address decoder and response multiplexer for N slaves on the CPU bus.
- Address phase: decodes the CPU address into one-hot HSEL lines from a configurable base/mask map.
- Data phase: tracks which slave is active, registered only on accepted transfers, and routes that slave's HRDATA/HREADY/HRESP back to the CPU.
- Adds an internal default slave (two-cycle ERROR for unmapped addresses), a stalled-slave timeout, and error capture registers.

---
 rtl/ahb_lite_decoder_mux.sv | 209 ++++++++++++++++++++
 tb/tb_ahb_lite_decoder_mux.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_decoder_mux.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_decoder_mux
// Description : AHB-lite address decoder and response multiplexer with an
//               internal default slave, stall timeout and error capture.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_decoder_mux #(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS =
    {32'h1001_4000, 32'h1001_3000, 32'h0C00_0000, 32'h0200_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFC00_0000, 32'hFFFF_0000},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          CPU_HADDR,
  input  logic [1:0]                     CPU_HTRANS,
  output logic [NUM_SLAVES-1:0]          HSEL,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_HRDATA,
  input  logic [NUM_SLAVES-1:0]          S_HREADYOUT,
  input  logic [NUM_SLAVES*2-1:0]        S_HRESP,
  output logic [DATA_WIDTH-1:0]          CPU_HRDATA,
  output logic                           CPU_HREADY,
  output logic [1:0]                     CPU_HRESP,
  output logic                           err_valid,
  output logic                           err_timeout,
  output logic [ADDR_WIDTH-1:0]          err_addr,
  input  logic                           err_clr
);

  localparam int c_sel_w = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLAVE = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } dp_state_t;

  dp_state_t               r_dp_state, w_state_nxt;
  logic [c_sel_w-1:0]      r_dp_sel, w_sel_nxt;
  logic [ADDR_WIDTH-1:0]   r_dp_addr, w_addr_nxt;

  logic                    r_err_valid;
  logic                    r_err_timeout;
  logic [ADDR_WIDTH-1:0]   r_err_addr;

  logic [NUM_SLAVES-1:0]   w_hit;
  logic [NUM_SLAVES-1:0]   w_hsel;
  logic [c_sel_w-1:0]      w_hit_idx;
  logic                    w_hit_any;
  logic [DATA_WIDTH-1:0]   w_rdata [NUM_SLAVES];
  logic [1:0]              w_resp  [NUM_SLAVES];

  logic                    w_hready;
  logic [1:0]              w_hresp;
  logic [DATA_WIDTH-1:0]   w_hrdata;
  logic                    w_accept;
  logic                    w_timeout_fire;
  logic                    w_err_new;
  logic                    w_err_is_to;
  logic [ADDR_WIDTH-1:0]   w_err_addr_new;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign w_hit[gi] = ((CPU_HADDR & ADDR_MASKS[gi*ADDR_WIDTH +: ADDR_WIDTH])
                          == BASE_ADDRS[gi*ADDR_WIDTH +: ADDR_WIDTH]);
      assign w_rdata[gi] = S_HRDATA[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_resp[gi]  = S_HRESP[gi*2 +: 2];
    end
  endgenerate

  // Scan from the top so the lowest-index hit is the one left standing.
  always_comb begin
    w_hsel    = '0;
    w_hit_idx = '0;
    w_hit_any = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hsel    = '0;
        w_hsel[i] = 1'b1;
        w_hit_idx = c_sel_w'(i);
        w_hit_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 2'b00;
    w_hrdata = '0;
    case (r_dp_state)
      ST_SLAVE: begin
        w_hready = S_HREADYOUT[r_dp_sel];
        w_hresp  = w_resp[r_dp_sel];
        w_hrdata = w_rdata[r_dp_sel];
      end
      ST_ERR1: begin
        w_hready = 1'b0;
        w_hresp  = 2'b01;
      end
      ST_ERR2: begin
        w_hresp  = 2'b01;
      end
      default: ;
    endcase
  end

  assign w_accept = w_hready & CPU_HTRANS[1];

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
      logic [c_cnt_w-1:0] r_cnt;
      logic               w_stalled;

      assign w_stalled      = (r_dp_state == ST_SLAVE) && !S_HREADYOUT[r_dp_sel];
      assign w_timeout_fire = w_stalled && (r_cnt == c_cnt_last);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_hready || w_timeout_fire) begin
          r_cnt <= '0;
        end else if (w_stalled) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign w_timeout_fire = 1'b0;
    end
  endgenerate

  // A timeout overrides the stalled slave; ERR1 always moves on since HREADY is low.
  always_comb begin
    w_state_nxt    = r_dp_state;
    w_sel_nxt      = r_dp_sel;
    w_addr_nxt     = r_dp_addr;
    w_err_new      = 1'b0;
    w_err_is_to    = 1'b0;
    w_err_addr_new = CPU_HADDR;
    if (w_timeout_fire) begin
      w_state_nxt    = ST_ERR1;
      w_err_new      = 1'b1;
      w_err_is_to    = 1'b1;
      w_err_addr_new = r_dp_addr;
    end else if (r_dp_state == ST_ERR1) begin
      w_state_nxt = ST_ERR2;
    end else if (w_hready) begin
      if (w_accept) begin
        w_addr_nxt = CPU_HADDR;
        if (w_hit_any) begin
          w_state_nxt = ST_SLAVE;
          w_sel_nxt   = w_hit_idx;
        end else begin
          w_state_nxt = ST_ERR1;
          w_err_new   = 1'b1;
        end
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_state <= ST_IDLE;
      r_dp_sel   <= '0;
      r_dp_addr  <= '0;
    end else begin
      r_dp_state <= w_state_nxt;
      r_dp_sel   <= w_sel_nxt;
      r_dp_addr  <= w_addr_nxt;
    end
  end

  // A clear coinciding with a fresh error lets the fresh error through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_addr    <= '0;
    end else if (w_err_new && (!r_err_valid || err_clr)) begin
      r_err_valid   <= 1'b1;
      r_err_timeout <= w_err_is_to;
      r_err_addr    <= w_err_addr_new;
    end else if (err_clr) begin
      r_err_valid   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_addr    <= '0;
    end
  end

  assign HSEL        = w_hsel;
  assign CPU_HRDATA  = w_hrdata;
  assign CPU_HREADY  = w_hready;
  assign CPU_HRESP   = w_hresp;
  assign err_valid   = r_err_valid;
  assign err_timeout = r_err_timeout;
  assign err_addr    = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_decoder_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_decoder_mux
// Description : Self-checking bench for ahb_lite_decoder_mux against a
//               transfer-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_decoder_mux;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     cpu_haddr;
  logic [1:0]        cpu_htrans;
  logic [NS-1:0]     hsel;
  logic [NS*DW-1:0]  s_hrdata;
  logic [NS-1:0]     s_hreadyout;
  logic [NS*2-1:0]   s_hresp;
  logic [DW-1:0]     cpu_hrdata;
  logic              cpu_hready;
  logic [1:0]        cpu_hresp;
  logic              err_valid;
  logic              err_timeout;
  logic [AW-1:0]     err_addr;
  logic              err_clr;

  always #5 clk = ~clk;

  ahb_lite_decoder_mux #(
    .NUM_SLAVES    (NS),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CPU_HADDR  (cpu_haddr),
    .CPU_HTRANS (cpu_htrans),
    .HSEL       (hsel),
    .S_HRDATA   (s_hrdata),
    .S_HREADYOUT(s_hreadyout),
    .S_HRESP    (s_hresp),
    .CPU_HRDATA (cpu_hrdata),
    .CPU_HREADY (cpu_hready),
    .CPU_HRESP  (cpu_hresp),
    .err_valid  (err_valid),
    .err_timeout(err_timeout),
    .err_addr   (err_addr),
    .err_clr    (err_clr)
  );

  // Memory map as seen by the CPU
  logic [31:0] m_base [NS] = '{32'h0200_0000, 32'h0C00_0000, 32'h1001_3000, 32'h1001_4000};
  logic [31:0] m_mask [NS] = '{32'hFFFF_0000, 32'hFC00_0000, 32'hFFFF_F000, 32'hFFFF_F000};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Stimulus for the next cycle
  logic [31:0] t_addr;
  logic [1:0]  t_trans;
  logic        t_clr;
  logic [NS-1:0] t_ready;
  logic [31:0] t_rdata [NS];
  logic [1:0]  t_resp  [NS];

  // Reference model: the transfer currently in its data phase
  int          m_kind;   // 0 none, 1 slave, 2 default-slave/timeout error
  int          m_idx;
  int          m_left;   // error cycles still to show
  int          m_waits;  // stalled cycles seen so far
  logic [31:0] m_paddr;
  logic        m_ev;
  logic        m_et;
  logic [31:0] m_ea;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] exp_hsel(input logic [31:0] a);
    int k;
    k = decode(a);
    return (k < 0) ? 4'b0000 : 4'(1 << k);
  endfunction

  task automatic model_reset();
    m_kind = 0; m_idx = 0; m_left = 0; m_waits = 0; m_paddr = '0;
    m_ev = 1'b0; m_et = 1'b0; m_ea = '0;
  endtask

  task automatic set_idle();
    t_addr = '0; t_trans = 2'b00; t_clr = 1'b0; t_ready = '1;
    for (int i = 0; i < NS; i++) begin
      t_rdata[i] = '0;
      t_resp[i]  = 2'b00;
    end
  endtask

  task automatic step();
    logic [31:0] e_data;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic        new_err;
    logic        new_to;
    logic [31:0] new_addr;
    int          k;
    @(negedge clk);
    cpu_haddr   = t_addr;
    cpu_htrans  = t_trans;
    err_clr     = t_clr;
    s_hreadyout = t_ready;
    for (int i = 0; i < NS; i++) begin
      s_hrdata[i*DW +: DW] = t_rdata[i];
      s_hresp[i*2 +: 2]    = t_resp[i];
    end
    #1;
    if (!rst_n) model_reset();
    e_data = '0; e_rdy = 1'b1; e_resp = 2'b00;
    if (m_kind == 1) begin
      e_data = t_rdata[m_idx]; e_rdy = t_ready[m_idx]; e_resp = t_resp[m_idx];
    end else if (m_kind == 2) begin
      e_rdy = (m_left == 1); e_resp = 2'b01;
    end
    check_eq("hsel", hsel, exp_hsel(t_addr));
    check_eq("hready", cpu_hready, e_rdy);
    check_eq("hresp", cpu_hresp, e_resp);
    if (!(m_kind == 2 && m_left == 2)) check_eq("hrdata", cpu_hrdata, e_data);
    check_eq("err_valid", err_valid, m_ev);
    check_eq("err_timeout", err_timeout, m_et);
    check_eq("err_addr", err_addr, m_ea);
    if (!rst_n) return;
    new_err = 1'b0; new_to = 1'b0; new_addr = '0;
    if (m_kind == 1 && !e_rdy) begin
      m_waits++;
      if (m_waits == TO) begin
        m_kind = 2; m_left = 2; new_err = 1'b1; new_to = 1'b1; new_addr = m_paddr;
      end
    end else if (m_kind == 2 && m_left == 2) begin
      m_left = 1;
    end else if (t_trans[1]) begin
      k = decode(t_addr);
      m_paddr = t_addr;
      if (k >= 0) begin
        m_kind = 1; m_idx = k; m_waits = 0;
      end else begin
        m_kind = 2; m_left = 2; new_err = 1'b1; new_addr = t_addr;
      end
    end else begin
      m_kind = 0;
    end
    if (new_err && (!m_ev || t_clr)) begin
      m_ev = 1'b1; m_et = new_to; m_ea = new_addr;
    end else if (t_clr) begin
      m_ev = 1'b0; m_et = 1'b0; m_ea = '0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'h0200_0000 | ($urandom & 32'h0000_FFFF);
      1:       return 32'h0C00_0000 | ($urandom & 32'h03FF_FFFF);
      2:       return 32'h1001_3000 | ($urandom & 32'h0000_0FFF);
      3:       return 32'h1001_4000 | ($urandom & 32'h0000_0FFF);
      4:       return 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    model_reset();
    set_idle();
    t_addr = 32'h1001_3000;
    step();
    step();
    rst_n = 1'b1;

    // IDLE and BUSY at mapped addresses leave the data phase idle
    t_addr = 32'h0200_0000; t_trans = 2'b01; step();
    t_trans = 2'b00; step();
    check_eq("busy_hready", cpu_hready, 1'b1);
    check_eq("busy_ev", err_valid, 1'b0);

    // Slave 2 single read
    set_idle();
    t_addr = 32'h1001_3004; t_trans = 2'b10; t_rdata[2] = 32'hA5A5_0001; step();
    check_eq("s2_hsel", hsel, 4'b0100);
    t_addr = '0; t_trans = 2'b00; step();
    check_eq("s2_rdata", cpu_hrdata, 32'hA5A5_0001);
    check_eq("s2_hresp", cpu_hresp, 2'b00);

    // Slave 0 stalls while the PLIC transfer waits in the address phase
    set_idle();
    t_addr = 32'h0200_0010; t_trans = 2'b10; step();
    t_ready[0] = 1'b0; t_addr = 32'h0C00_0000;
    t_rdata[0] = 32'h0000_1111; t_rdata[1] = 32'h0000_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_hready", cpu_hready, 1'b0);
    end
    t_ready[0] = 1'b1; step();
    t_trans = 2'b00; step();
    check_eq("plic_rdata", cpu_hrdata, 32'h0000_2222);

    // Unmapped address goes to the default slave
    set_idle();
    t_addr = 32'h8000_0000; t_trans = 2'b10; step();
    check_eq("unmap_hsel", hsel, 4'b0000);
    set_idle(); step();
    check_eq("err1_hready", cpu_hready, 1'b0);
    step();
    check_eq("err2_hready", cpu_hready, 1'b1);
    check_eq("err2_hresp", cpu_hresp, 2'b01);
    check_eq("unmap_eaddr", err_addr, 32'h8000_0000);
    t_clr = 1'b1; step(); t_clr = 1'b0;

    // Slave 3 never responds
    t_addr = 32'h1001_4000; t_trans = 2'b10; step();
    set_idle(); t_ready[3] = 1'b0;
    for (int i = 0; i < TO; i++) step();
    step();
    check_eq("to_err1_hresp", cpu_hresp, 2'b01);
    check_eq("to_err1_hready", cpu_hready, 1'b0);
    step();
    check_eq("to_err_timeout", err_timeout, 1'b1);
    step();
    check_eq("to_after_hready", cpu_hready, 1'b1);
    t_clr = 1'b1; step(); t_clr = 1'b0;

    // Asynchronous reset in the middle of ERR1
    t_addr = 32'h8000_0000; t_trans = 2'b10; step();
    set_idle(); step();
    rst_n = 1'b0;
    #1;
    check_eq("arst_hready", cpu_hready, 1'b1);
    check_eq("arst_hresp", cpu_hresp, 2'b00);
    check_eq("arst_ev", err_valid, 1'b0);
    model_reset();
    step();
    rst_n = 1'b1;

    // Clear and a new error on the same edge: the new error is kept
    t_addr = 32'h8000_0100; t_trans = 2'b10; step();
    set_idle(); step();
    t_addr = 32'h9000_0000; t_trans = 2'b10; t_clr = 1'b1; step();
    set_idle(); step();
    check_eq("clrnew_ev", err_valid, 1'b1);
    check_eq("clrnew_eaddr", err_addr, 32'h9000_0000);

    // Random traffic with periodic windows where every slave hangs
    for (int c = 0; c < 2000; c++) begin
      t_addr  = rand_addr();
      t_trans = 2'($urandom);
      t_clr   = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NS; i++) begin
        t_rdata[i] = $urandom;
        t_resp[i]  = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
        t_ready[i] = ((c % 128) >= 96) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
